// File: rtl/raster_pkg.sv
// ---------------------------------------------------------------------------
// raster_pkg
// Shared types and constants for the raster pixel stream transmitter.
//   state_t : transmitter FSM states (idle, active line, line blank, frame blank)
//   flags_t : per-beat framing flags carried with each pixel
//   COORD_W : width of the row/column coordinate counters
// ---------------------------------------------------------------------------
package raster_pkg;

    localparam int COORD_W = 10;
    localparam int FLAGS_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } flags_t;

endpackage

// File: rtl/raster_fifo2.sv
// ---------------------------------------------------------------------------
// raster_fifo2
// Two-entry FIFO holding {flags, pixel} entries between the frame memory read
// path and the output stream.
//   clk, rst_n : clock, synchronous active-low reset
//   i_flush    : synchronous clear of all entries
//   i_push     : write i_din (caller guarantees the FIFO is not full)
//   i_pop      : drop the head entry (caller guarantees the FIFO is not empty)
//   o_dout     : head entry, stable until popped
//   o_valid    : FIFO holds at least one entry
//   o_count    : number of stored entries (0..2)
// Storage is cleared on reset/flush so the head reads as zero when empty
// after reset.
// ---------------------------------------------------------------------------
module raster_fifo2 #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_valid,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem0;
    logic [W-1:0] r_mem1;
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) begin
                if (r_wptr) r_mem1 <= i_din;
                else        r_mem0 <= i_din;
                r_wptr <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_rptr ? r_mem1 : r_mem0;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/raster_stream_tx.sv
// ---------------------------------------------------------------------------
// raster_stream_tx
// Reads one ROW x COL frame from a frame memory in raster order on a start
// pulse and emits it as a valid/ready pixel stream with sof/eol/eof flags.
// HBLANK idle cycles follow each line, VBLANK idle cycles follow the frame
// (counted once the output buffer has drained), then frame_done pulses.
//
// Optional feature macro: RASTER_TX_TPG_EN
//   defined   : pixel data = (col ^ row) truncated, src_data ignored
//   undefined : pixel data = src_data
//
// Ports
//   clk, rst_n            : clock, synchronous active-low reset
//   start                 : frame request, only sampled in idle
//   rd_en, rd_addr        : frame memory read strobe / address
//   src_data              : read data, valid the cycle after rd_en
//   dout_data/valid/ready : output pixel stream
//   dout_sof/eol/eof      : framing flags of the current beat
//   busy                  : frame in progress
//   frame_done            : one-cycle pulse at the end of frame blanking
//   dbg_state             : current FSM state
//
// Handshake: a beat transfers on a cycle where dout_valid && dout_ready; while
// dout_valid is high and dout_ready low, all dout_* hold their values.
// ---------------------------------------------------------------------------
module raster_stream_tx
    import raster_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROW        = 480,
    parameter int COL        = 640,
    parameter int HBLANK     = 16,
    parameter int VBLANK     = 64,
    parameter int ADDR_WIDTH = $clog2(ROW*COL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_sof,
    output logic                  dout_eol,
    output logic                  dout_eof,
    output logic                  busy,
    output logic                  frame_done,
    output state_t                dbg_state
);

    localparam int BLANK_W = 16;
    localparam int ENTRY_W = FLAGS_W + DATA_WIDTH;
    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(COL - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROW - 1);
    localparam logic [BLANK_W-1:0] HB_LAST  = BLANK_W'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [BLANK_W-1:0] VB_LAST  = BLANK_W'((VBLANK > 0) ? VBLANK - 1 : 0);

    state_t                r_state;
    logic [COORD_W-1:0]    r_row;
    logic [COORD_W-1:0]    r_col;
    logic [BLANK_W-1:0]    r_blank;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inflight;
    flags_t                r_flags_d;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_fifo_valid;
    logic [1:0]            w_fifo_count;
    logic [ENTRY_W-1:0]    w_fifo_dout;
    logic [2:0]            w_credit;
    logic                  w_rd;
    logic                  w_start_acc;
    logic                  w_drained;
    flags_t                w_issue_flags;
    logic [DATA_WIDTH-1:0] w_pix;

    assign w_pop       = w_fifo_valid && dout_ready;
    // Occupancy the FIFO will have once this cycle's pop and any in-flight
    // read have landed; a new read is only issued if it will find a slot.
    assign w_credit    = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd        = (r_state == ST_ACTIVE) && (w_credit < 3'd2);
    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_drained   = (w_fifo_count == 2'd0) && !r_inflight;

    assign w_issue_flags.sof = (r_row == '0) && (r_col == '0);
    assign w_issue_flags.eol = (r_col == COL_LAST);
    assign w_issue_flags.eof = (r_col == COL_LAST) && (r_row == ROW_LAST);

`ifdef RASTER_TX_TPG_EN
    logic [DATA_WIDTH-1:0] r_tpg_d;
    logic [COORD_W-1:0]    w_xor;

    assign w_xor = r_col ^ r_row;

    // Pattern value follows the same one-cycle delay as the memory data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tpg_d <= '0;
        end else if (w_rd) begin
            r_tpg_d <= DATA_WIDTH'(w_xor);
        end
    end

    assign w_pix = r_tpg_d;
`else
    assign w_pix = src_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_blank    <= '0;
            r_addr     <= '0;
            r_inflight <= 1'b0;
            r_flags_d  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_rd;
            if (w_rd) begin
                r_flags_d <= w_issue_flags;
                // Wrap to 0 on the last pixel so the idle address is 0.
                r_addr    <= w_issue_flags.eof ? '0 : r_addr + ADDR_WIDTH'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_ACTIVE;
                        r_busy  <= 1'b1;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_blank <= '0;
                        r_addr  <= '0;
                    end
                end

                ST_ACTIVE: begin
                    if (w_rd) begin
                        if (r_col == COL_LAST) begin
                            r_col   <= '0;
                            r_blank <= '0;
                            if (r_row == ROW_LAST) begin
                                r_state <= ST_VBLANK;
                            end else if (HBLANK == 0) begin
                                r_row <= r_row + COORD_W'(1);
                            end else begin
                                r_state <= ST_HBLANK;
                            end
                        end else begin
                            r_col <= r_col + COORD_W'(1);
                        end
                    end
                end

                ST_HBLANK: begin
                    if (r_blank == HB_LAST) begin
                        r_state <= ST_ACTIVE;
                        r_row   <= r_row + COORD_W'(1);
                        r_blank <= '0;
                    end else begin
                        r_blank <= r_blank + BLANK_W'(1);
                    end
                end

                ST_VBLANK: begin
                    // Frame blanking only counts once every beat has left.
                    if (w_drained) begin
                        if ((VBLANK == 0) || (r_blank == VB_LAST)) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_blank <= '0;
                        end else begin
                            r_blank <= r_blank + BLANK_W'(1);
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    raster_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_start_acc),
        .i_push  (r_inflight),
        .i_din   ({r_flags_d, w_pix}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign rd_en      = w_rd;
    assign rd_addr    = r_addr;
    assign {dout_sof, dout_eol, dout_eof, dout_data} = w_fifo_dout;
    assign dout_valid = w_fifo_valid;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_raster_stream_tx.sv
module tb_raster_stream_tx;
    import raster_pkg::*;

    localparam int ROW  = 4;
    localparam int COL  = 8;
    localparam int HB   = 2;
    localparam int VB   = 3;
    localparam int NPIX = ROW * COL;
    localparam int AW   = 5;
    localparam int DW   = 8;
    // start-sample edge to frame_done: 4*(8+2) - 2 + 3 + 2
    localparam int FRAME_LEN = 43;

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ready = 1'b1;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] src_data = '0;
    logic [DW-1:0] dout_data;
    logic          dout_valid, dout_sof, dout_eol, dout_eof, busy, frame_done;
    state_t        dbg_state;

    logic          h_start = 1'b0;
    logic          h_ready = 1'b1;
    logic          h_rd_en;
    logic [AW-1:0] h_rd_addr;
    logic [DW-1:0] h_src = '0;
    logic [DW-1:0] h_data;
    logic          h_valid, h_sof, h_eol, h_eof, h_busy, h_done;
    state_t        h_state;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    raster_stream_tx #(
        .DATA_WIDTH(DW), .ROW(ROW), .COL(COL), .HBLANK(HB), .VBLANK(VB), .ADDR_WIDTH(AW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .src_data(src_data), .dout_data(dout_data), .dout_valid(dout_valid),
        .dout_ready(ready), .dout_sof(dout_sof), .dout_eol(dout_eol), .dout_eof(dout_eof),
        .busy(busy), .frame_done(frame_done), .dbg_state(dbg_state)
    );

    raster_stream_tx #(
        .DATA_WIDTH(DW), .ROW(ROW), .COL(COL), .HBLANK(0), .VBLANK(VB), .ADDR_WIDTH(AW)
    ) u_dut_h0 (
        .clk(clk), .rst_n(rst_n), .start(h_start), .rd_en(h_rd_en), .rd_addr(h_rd_addr),
        .src_data(h_src), .dout_data(h_data), .dout_valid(h_valid),
        .dout_ready(h_ready), .dout_sof(h_sof), .dout_eol(h_eol), .dout_eof(h_eof),
        .busy(h_busy), .frame_done(h_done), .dbg_state(h_state)
    );

    // ---------------- frame memory models ----------------
    function automatic logic [DW-1:0] mem_val(input int a);
        return DW'(a * 37 + 5);
    endfunction

    always @(posedge clk) begin
`ifdef RASTER_TX_TPG_EN
        if (rd_en)   src_data <= 8'hFF;
        if (h_rd_en) h_src    <= 8'hFF;
`else
        if (rd_en)   src_data <= mem_val(int'(rd_addr));
        if (h_rd_en) h_src    <= mem_val(int'(h_rd_addr));
`endif
    end

    // ---------------- scoreboard ----------------
    logic [DW+2:0] exp_q[$];
    logic [DW+2:0] exp_h0_q[$];

    function automatic logic [DW+2:0] exp_beat(input int i);
        int r;
        int c;
        logic [DW-1:0] d;
        logic [COORD_W-1:0] x;
        r = i / COL;
        c = i % COL;
`ifdef RASTER_TX_TPG_EN
        x = COORD_W'(c) ^ COORD_W'(r);
        d = x[DW-1:0];
`else
        x = '0;
        d = mem_val(i);
`endif
        return {(i == 0), (c == COL - 1), (i == NPIX - 1), d};
    endfunction

    task automatic push_frame();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_beat(i));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    int            beats_seen = 0;
    int            sof_cyc = 0;
    int            done_cnt = 0;
    int            outst = 0;
    int            exp_addr = 0;
    logic          stall = 1'b0;
    logic [DW+2:0] stall_val = '0;

    always @(negedge clk) begin
        logic [DW+2:0] act;
        logic [DW+2:0] expv;
        act = {dout_sof, dout_eol, dout_eof, dout_data};
        if (!rst_n) begin
            stall    = 1'b0;
            outst    = 0;
            exp_addr = 0;
        end else begin
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(exp_addr));
                exp_addr = (exp_addr + 1) % NPIX;
                outst++;
            end
            if (stall) begin
                check("stall_valid", 32'(dout_valid), 32'd1);
                check("stall_stable", 32'(act), 32'(stall_val));
            end
            if (dout_valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat (cycle %0d)", act, cyc);
                end else begin
                    expv = exp_q.pop_front();
                    check("beat", 32'(act), 32'(expv));
                end
                beats_seen++;
                if (dout_sof) sof_cyc = cyc;
                outst--;
            end
            if (rd_en) check("outstanding_le2", 32'(outst <= 2), 32'd1);
            stall     = dout_valid && !ready;
            stall_val = act;
            if (frame_done) done_cnt++;
        end
    end

    int h_beats = 0;
    int h_first = 0;
    int h_last = 0;

    always @(negedge clk) begin
        logic [DW+2:0] act;
        logic [DW+2:0] expv;
        act = {h_sof, h_eol, h_eof, h_data};
        if (rst_n && h_valid && h_ready) begin
            if (exp_h0_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL h0_unexpected_beat: got 0x%0h expected no beat", act);
            end else begin
                expv = exp_h0_q.pop_front();
                check("h0_beat", 32'(act), 32'(expv));
            end
            h_beats++;
            if (h_sof) h_first = cyc;
            if (h_eof) h_last = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    int s_cyc = 0;

    task automatic start_frame();
        @(posedge clk);
        #1 start = 1'b1;
        push_frame();
        @(posedge clk);
        #1 start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, input string name, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                dcyc = cyc;
                checks++;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no frame_done expected within %0d cycles", name, budget);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int dcyc;
        int d1;
        int dn;
        int base;
        int cnt0;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({rd_en, rd_addr, dout_data, dout_valid, dout_sof, dout_eol, dout_eof, busy, frame_done}),
              32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        wait_cycles(2);

        // 1: full frame, ready held high
        ready = 1'b1;
        cnt0 = done_cnt;
        start_frame();
        check("busy_after_start", 32'(busy), 32'd1);
        check("rd_en_after_start", 32'(rd_en), 32'd1);
        check("rd_addr_after_start", 32'(rd_addr), 32'd0);
        wait_done(200, "frame1", dcyc);
        check("frame1_len", 32'(dcyc - s_cyc), 32'(FRAME_LEN));
        check("frame1_first_beat_latency", 32'(sof_cyc - s_cyc), 32'd2);
        check("frame1_busy_at_done", 32'(busy), 32'd0);
        wait_cycles(3);
        check("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame1_done_count", 32'(done_cnt - cnt0), 32'd1);
        check("frame1_busy_low", 32'(busy), 32'd0);

        // 2: pseudo-random backpressure
        cnt0 = done_cnt;
        start_frame();
        dcyc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                dcyc = cyc;
                break;
            end
            ready = ($urandom_range(0, 99) < 55);
        end
        check("frame2_done_seen", 32'(dcyc >= 0), 32'd1);
        ready = 1'b1;
        wait_cycles(3);
        check("frame2_queue_empty", 32'(exp_q.size()), 32'd0);
        check("frame2_done_count", 32'(done_cnt - cnt0), 32'd1);

        // 3: HBLANK=0 instance, contiguous lines
        for (int i = 0; i < NPIX; i++) exp_h0_q.push_back(exp_beat(i));
        @(posedge clk);
        #1 h_start = 1'b1;
        @(posedge clk);
        #1 h_start = 1'b0;
        base = cyc;
        for (int i = 0; i < 200 && h_beats < NPIX; i++) @(posedge clk);
        wait_cycles(10);
        check("h0_beat_count", 32'(h_beats), 32'(NPIX));
        check("h0_first_latency", 32'(h_first - base), 32'd2);
        check("h0_contiguous", 32'(h_last - h_first), 32'(NPIX - 1));
        check("h0_busy_low", 32'(h_busy), 32'd0);

        // 4a: start pulsed mid-frame is ignored
        cnt0 = done_cnt;
        start_frame();
        wait_cycles(10);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(200, "midpulse", dcyc);
        check("midpulse_len", 32'(dcyc - s_cyc), 32'(FRAME_LEN));
        wait_cycles(60);
        check("midpulse_done_count", 32'(done_cnt - cnt0), 32'd1);
        check("midpulse_no_restart", 32'(busy), 32'd0);

        // 4b: start held high gives back-to-back frames
        cnt0 = done_cnt;
        push_frame();
        push_frame();
        @(posedge clk);
        #1 start = 1'b1;
        dn = 0;
        d1 = 0;
        dcyc = 0;
        for (int i = 0; i < 400 && dn < 2; i++) begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                dn++;
                if (dn == 1) d1 = cyc;
                else dcyc = cyc;
            end
        end
        start = 1'b0;
        check("b2b_two_frames", 32'(dn), 32'd2);
        check("b2b_spacing", 32'(dcyc - d1), 32'(FRAME_LEN + 1));
        wait_cycles(60);
        check("b2b_done_count", 32'(done_cnt - cnt0), 32'd2);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset mid-frame during a stall
        base = beats_seen;
        ready = 1'b1;
        start_frame();
        for (int i = 0; i < 200 && beats_seen < base + 13; i++) @(posedge clk);
        #1;
        check("reset_reached_beat13", 32'(beats_seen - base), 32'd13);
        ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_outputs",
              32'({rd_en, rd_addr, dout_data, dout_valid, dout_sof, dout_eol, dout_eof, busy, frame_done}),
              32'd0);
        check("midreset_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        rst_n = 1'b1;
        ready = 1'b1;
        wait_cycles(4);
        check("no_stale_beat", 32'(dout_valid), 32'd0);
        start_frame();
        check("restart_addr", 32'(rd_addr), 32'd0);
        wait_done(200, "restart", dcyc);
        check("restart_len", 32'(dcyc - s_cyc), 32'(FRAME_LEN));
        check("restart_first_latency", 32'(sof_cyc - s_cyc), 32'd2);
        wait_cycles(3);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test expected finish before 300000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/raster_stream_tx.md
# raster_stream_tx

Raster pixel stream transmitter: on a start pulse it reads one ROW×COL frame from a frame memory in raster order and emits it as a valid/ready pixel stream. Each beat carries start-of-frame, end-of-line and end-of-frame flags, and programmable blanking is inserted between lines and after the frame. It is the source side of the pixel interface whose sink counts valid beats into col/row coordinates. It feeds the rectification pipeline and benches from stored images.

## Interface
- DATA_WIDTH, 8, pixel width
- ROW, 480, lines per frame
- COL, 640, pixels per line
- HBLANK, 16, idle cycles without reads after each line, ≥0
- VBLANK, 64, idle cycles after the last line before frame_done, ≥0
- ADDR_WIDTH, $clog2(ROW*COL), frame memory address width
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  frame request; sampled only in IDLE
- rd_en  out  1  frame memory read strobe
- rd_addr  out  ADDR_WIDTH  read address = row*COL+col
- src_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en
- dout_data  out  DATA_WIDTH  pixel
- dout_valid  out  1  beat valid
- dout_ready  in  1  sink accepts beat
- dout_sof  out  1  beat is pixel (0,0)
- dout_eol  out  1  beat is col COL-1
- dout_eof  out  1  beat is (ROW-1,COL-1)
- busy  out  1  high from start acceptance until frame_done
- frame_done  out  1  one-cycle pulse at end of VBLANK

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE→ACTIVE when start=1. start outside IDLE is ignored.
- In ACTIVE, each read advances col. At col COL-1 the FSM goes to HBLANK, or to VBLANK if row is ROW-1.
- HBLANK→ACTIVE after HBLANK cycles, with row+1 and col 0. HBLANK=0 means a direct ACTIVE→ACTIVE line change.
- VBLANK waits for VBLANK cycles and for the output buffer to be empty. It then pulses frame_done and returns to IDLE.
- Back-to-back frames: start high in the frame_done cycle is sampled in the following IDLE cycle.
- Credit flow control uses a 2-entry output FIFO:
  - rd_en = state==ACTIVE && (fifo_count + inflight − pop) < 2.
  - pop = dout_valid && dout_ready. The credit returns in the same cycle.
- rd_addr is kept incrementally: it starts at 0 and increments on each rd_en, with no multiplier.
- The sof/eol/eof flags are computed at issue time, delayed one cycle alongside src_data, and stored with the pixel in the FIFO.
- While dout_valid=1 and dout_ready=0, dout_* stay stable.
- Reset (mid-frame included): state IDLE, FIFO flushed, in-flight read discarded, counters 0. All outputs are 0: rd_en, rd_addr, dout_*, busy, frame_done.

## Timing
- start sampled at edge E0: busy=1 and rd_en=1 with rd_addr=0 from E0.
- src_data is captured at E1. dout_valid=1 with dout_sof=1 from E2. Latency start→first beat is 2 cycles.
- With dout_ready held 1: one beat per cycle within a line; a gap of HBLANK cycles between lines.
- Frame length with dout_ready=1: ROW*(COL+HBLANK) − HBLANK + VBLANK + 2 cycles from start to frame_done, ±1 for the FIFO drain condition. The exact figure is pinned by the bench.
- Stalls never drop or duplicate a beat. Reads resume in the cycle the stall clears.

## Configuration
- RASTER_TX_TPG_EN defined: rd_en is still generated, but src_data is ignored. Pixel data = (col ^ row) truncated to DATA_WIDTH, so the block acts as a standalone test-pattern generator.
- RASTER_TX_TPG_EN undefined: data comes from src_data. No pattern logic is present.

## Structure
- Package raster_pkg: state enum (IDLE/ACTIVE/HBLANK/VBLANK), flag-bundle struct {sof, eol, eof}, and the coordinate width constant (10).
- Sub-module raster_fifo2: 2-entry FIFO of {flags, data} with count, push, pop and flush.
- Top level: FSM, counters, address and credit logic.

## Test plan
- ROW=4, COL=8, HBLANK=2, VBLANK=3, dout_ready=1, start at E0 → rd_addr 0..31 in order; first beat at E2 with sof; eol on beats 7/15/23/31; eof on beat 31; one frame_done; busy low afterwards.
- Same parameters, dout_ready toggled pseudo-randomly → all 32 beats in order, data stable during stalls, never more than 2 reads outstanding.
- HBLANK=0 → lines contiguous; 32 beats in 32 consecutive cycles after the first.
- start pulsed while busy, and start held high continuously → the mid-frame pulse is ignored; the held start gives back-to-back frames, each with exactly one frame_done.
- rst_n low on beat 13 with dout_ready=0 → next cycle all outputs 0. A fresh start restarts at addr 0 with sof; no stale beat appears.
- RASTER_TX_TPG_EN defined, src_data driven with 0xFF → beat (row 2, col 5) = 0x07.
